mul_sequencer: RTL
==================

MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width, even, >= 4; HI/LO are each WIDTH bits.
REQ-002 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port clear  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin a signed multiply.
REQ-005 SHALL have port op_q  input  WIDTH  multiplier Q, two's complement.
REQ-006 SHALL have port op_m  input  WIDTH  multiplicand M, two's complement.
REQ-007 SHALL have port busy  output  1  high while a multiply is in progress (RUN state).
REQ-008 SHALL have port done  output  1  one-cycle pulse when hi/lo hold a new result.
REQ-009 SHALL have port hi  output  WIDTH  upper half of last signed product.
REQ-010 SHALL have port lo  output  WIDTH  lower half of last signed product.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE), both registered-state decodes.
REQ-012 SHALL accept start only on an edge where state is IDLE or DONE and start=1: latch op_q and op_m, clear 2*WIDTH accumulator and digit counter, go to RUN.
REQ-013 SHALL ignore start while in RUN; latched operands SHALL NOT change during RUN regardless of op_q/op_m activity.
REQ-014 SHALL process exactly one radix-4 Booth digit per RUN cycle, WIDTH/2 digits total (16 at WIDTH=32), digit i in 0..WIDTH/2-1 recoded from {Q[2i+1],Q[2i],Q[2i-1]} with Q[-1]=0.
REQ-015 SHALL map digits: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M; partial product shifted left by 2i before accumulation.
REQ-016 SHALL sign-extend M to 2*WIDTH bits before forming +/-M and +/-2M; accumulation modulo 2^(2*WIDTH), carries beyond discarded.
REQ-017 SHALL, on the edge that accumulates the final digit, load hi/lo with the complete product and move to DONE.
REQ-018 Latency SHALL be fixed: acceptance edge E0, digits on E1..E(WIDTH/2), done high for the cycle following E(WIDTH/2) (16 cycles after E0 at WIDTH=32), independent of operand values.
REQ-019 SHALL leave DONE after exactly one cycle: to RUN if start=1 on that edge (back-to-back accept), else to IDLE.
REQ-020 hi/lo SHALL hold their value from the last completed multiply until the next completion; they SHALL NOT show intermediate accumulator values.
REQ-021 Result SHALL equal the exact signed product for all operand pairs, including most-negative x most-negative and most-negative x -1.

Reset
REQ-022 clear=1 on an edge SHALL force state IDLE, busy=0, done=0, hi=0, lo=0, counter and accumulator 0, with priority over start.
REQ-023 clear asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow, and hi/lo SHALL read 0.
REQ-024 start sampled on the same edge as clear SHALL be dropped; a new start is needed after clear deasserts.

Verification
REQ-025 op_q=7, op_m=6, start one cycle -> busy high 16 cycles, done pulse at cycle 17 after acceptance, hi=0x00000000, lo=0x0000002A.
REQ-026 op_q=0xFFFFFFFF, op_m=0xFFFFFFFF -> hi=0x00000000, lo=0x00000001; op_q=0xFFFFFFFF, op_m=0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFFB.
REQ-027 op_q=0x80000000, op_m=0x80000000 -> hi=0x40000000, lo=0x00000000; op_q=0x80000000, op_m=0xFFFFFFFF -> hi=0x00000000, lo=0x80000000.
REQ-028 start held high continuously with changing operands -> operands latched only at acceptance, each result exact, consecutive done pulses exactly 17 cycles apart (DONE->RUN back-to-back).
REQ-029 clear pulsed after digit 8 of a running multiply -> next cycle busy=0, done never pulses, hi=lo=0; subsequent 3 x -4 completes with hi=0xFFFFFFFF, lo=0xFFFFFFF4.
REQ-030 Randomized signed operands (>=10k pairs) against a 64-bit signed reference model; latency assertion (done exactly 17 cycles after accept) checked on every transaction.

Source files
------------

// File: rtl/mul_sequencer.sv
// Sequential signed multiplier: one radix-4 Booth digit per cycle, WIDTH/2 cycles per product.
// hi/lo update only when a product completes; clear is synchronous and overrides start.
module mul_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] op_q,
  input  logic [WIDTH-1:0] op_m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned Digits = WIDTH / 2;
  localparam int unsigned CntW   = (Digits > 1) ? $clog2(Digits) : 1;
  localparam logic [CntW-1:0] LastDigit = CntW'(Digits - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   q_q, m_q;
  logic [2*WIDTH-1:0] acc_q, acc_next, m_ext, pp;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH:0]     q_ext;
  logic [2:0]         triplet;
  logic               accept, last;

  assign accept = start && ((state_q == StIdle) || (state_q == StDone));
  assign last   = (cnt_q == LastDigit);

  // Appending a zero below Q supplies the Q[-1] bit of the first digit.
  assign q_ext   = {q_q, 1'b0};
  assign triplet = 3'(q_ext >> {cnt_q, 1'b0});
  assign m_ext   = {{WIDTH{m_q[WIDTH-1]}}, m_q};

  always_comb begin
    pp = '0;
    case (triplet)
      3'b001, 3'b010: pp = m_ext;
      3'b011:         pp = m_ext << 1;
      3'b100:         pp = -(m_ext << 1);
      3'b101, 3'b110: pp = -m_ext;
      default:        pp = '0;
    endcase
  end

  assign acc_next = acc_q + (pp << {cnt_q, 1'b0});

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = accept ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= StIdle;
      q_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        q_q   <= op_q;
        m_q   <= op_m;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (state_q == StRun) begin
        acc_q <= acc_next;
        cnt_q <= cnt_q + CntW'(1);
        if (last) begin
          hi <= acc_next[2*WIDTH-1:WIDTH];
          lo <= acc_next[WIDTH-1:0];
        end
      end
    end
  end

endmodule
